// File: rtl/mac_sequencer_if.sv
// Interface bundling the job, operand, FMA and result signals of mac_sequencer.
// The slave modport is the sequencer side. The master modport is the side that
// drives jobs and operands and hosts the FMA.
interface mac_sequencer_if #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    // job request
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      init_acc;

    // operand stream
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;

    // external FMA
    logic [15:0]      fma_a;
    logic [15:0]      fma_b;
    logic [31:0]      fma_c;
    logic [31:0]      fma_out;

    // result port
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             busy;

    modport slave (
        input  start, len, init_acc, in_valid, in_a, in_b, fma_out, res_ready,
        output in_ready, fma_a, fma_b, fma_c, res_valid, res_data, busy
    );

    modport master (
        output start, len, init_acc, in_valid, in_a, in_b, fma_out, res_ready,
        input  in_ready, fma_a, fma_b, fma_c, res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_sequencer.sv
// Accumulation-loop controller for an external combinational bf16 x bf16 + fp32 FMA.
// The block streams one operand pair per cycle into the FMA and feeds the FMA
// result back as the next addend. When the job ends it holds the final sum on a
// valid/ready result port. The block does no arithmetic, so the accumulator bits
// pass through unchanged.
module mac_sequencer #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    mac_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc, acc_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             run, hs;

    assign run = (state == RUN);
    assign hs  = run && bus.in_valid;

    // State, accumulator and remaining-element counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. A zero-length job skips RUN, and its result is init_acc.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt = bus.init_acc;
                    if (bus.len != '0) begin
                        cnt_nxt   = bus.len;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    acc_nxt = bus.fma_out;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. The operands are forced to zero outside RUN. The addend and the
    // result always show the accumulator, which makes res_data stable in DONE.
    always_comb begin
        bus.in_ready  = run;
        bus.fma_a     = run ? bus.in_a : 16'h0000;
        bus.fma_b     = run ? bus.in_b : 16'h0000;
        bus.fma_c     = acc;
        bus.res_valid = (state == DONE);
        bus.res_data  = acc;
        bus.busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer. The bench models the FMA as an ideal
// fp32 a*b+c. The operands are small bf16 integers, so every partial sum is
// exact, and the expected values are plain real-number sums of the products.
module tb_mac_sequencer;
    localparam int MAX_LEN = 256;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_sequencer_if #(.MAX_LEN(MAX_LEN)) bus();
    mac_sequencer #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [31:0] res;

    function automatic real fp2r(input logic [31:0] b);
        int  e;
        real v;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic s;
        real  a;
        int   e;
        longint f;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
        f = longint'((a - 1.0) * 8388608.0);
        return {s, 8'(e + 127), 23'(f)};
    endfunction

    function automatic logic [15:0] rnd_bf();
        logic [31:0] v;
        v = r2fp(real'($urandom_range(1, 16)));
        v[31] = 1'($urandom_range(0, 1));
        return v[31:16];
    endfunction

    // ideal FMA, combinational on the sequencer's operand outputs
    always_comb
        bus.fma_out = r2fp(fp2r({bus.fma_a, 16'h0}) * fp2r({bus.fma_b, 16'h0}) + fp2r(bus.fma_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Run one job from IDLE using qa/qb. The task enters and leaves at posedge+1.
    task automatic do_job(input int n, input logic [31:0] init, input int gap,
                          input int rdly, input bit poke, output logic [31:0] r);
        real part;
        part = fp2r(init);
        bus.start = 1'b1; bus.len = LEN_W'(n); bus.init_acc = init;
        mid(); chk("idle_busy", 32'(bus.busy), 0); chk("idle_rdy", 32'(bus.in_ready), 0);
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < ((i > 0) ? gap : 0); g++) begin
                bus.in_valid = 1'b0; bus.start = poke; bus.init_acc = $urandom;
                bus.len = LEN_W'($urandom_range(0, 8));
                mid();
                chk("stall_rdy", 32'(bus.in_ready), 1);
                chk("stall_acc", bus.fma_c, r2fp(part));
                cyc();
            end
            bus.in_valid = 1'b1; bus.in_a = qa[i]; bus.in_b = qb[i];
            bus.start = poke; bus.init_acc = $urandom;
            mid();
            chk("run_rdy", 32'(bus.in_ready), 1);
            chk("run_busy", 32'(bus.busy), 1);
            chk("run_fa", 32'(bus.fma_a), 32'(qa[i]));
            chk("run_acc", bus.fma_c, r2fp(part));
            cyc();
            part = part + fp2r({qa[i], 16'h0}) * fp2r({qb[i], 16'h0});
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < rdly; k++) begin
            bus.res_ready = 1'b0; bus.start = poke; bus.init_acc = $urandom;
            mid();
            chk("hold_vld", 32'(bus.res_valid), 1);
            chk("hold_data", bus.res_data, r2fp(part));
            chk("hold_rdy", 32'(bus.in_ready), 0);
            cyc();
        end
        // the start pulse in the handshake cycle must be ignored
        bus.res_ready = 1'b1; bus.start = 1'b1; bus.len = LEN_W'(3);
        mid();
        chk("res_vld", 32'(bus.res_valid), 1);
        chk("res_data", bus.res_data, r2fp(part));
        chk("res_fa0", 32'(bus.fma_a), 0);
        r = bus.res_data;
        cyc();
        bus.res_ready = 1'b0; bus.start = 1'b0;
        mid();
        chk("post_vld", 32'(bus.res_valid), 0);
        chk("post_busy", 32'(bus.busy), 0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b1; bus.len = LEN_W'(3); bus.init_acc = 32'h12345678;
        bus.in_valid = 1'b1; bus.in_a = 16'h4000; bus.in_b = 16'h4000; bus.res_ready = 1'b0;
        cyc(); cyc();
        mid();
        chk("rst_rdy", 32'(bus.in_ready), 0);
        chk("rst_vld", 32'(bus.res_valid), 0);
        chk("rst_data", bus.res_data, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_fa", 32'(bus.fma_a), 0);
        chk("rst_fb", 32'(bus.fma_b), 0);
        chk("rst_fc", bus.fma_c, 0);
        cyc();
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        mid(); chk("idle_after_rst", 32'(bus.busy), 0);
        cyc();

        // basic job: 1 + 1*2 + 1*2 = 5
        qa = '{16'h3F80, 16'h3F80}; qb = '{16'h4000, 16'h4000};
        do_job(2, 32'h3F800000, 0, 0, 1'b0, res);
        chk("basic_res", res, 32'h40A00000);

        // the same job with input stalls, result backpressure and start pokes
        do_job(2, 32'h3F800000, 3, 4, 1'b1, res);
        chk("stall_res", res, 32'h40A00000);

        // zero length
        do_job(0, 32'hC0000000, 0, 1, 1'b0, res);
        chk("zero_res", res, 32'hC0000000);

        // randomized jobs against the sum of products
        for (int j = 0; j < 6; j++) begin
            int n;
            real tot;
            logic [31:0] init;
            n = $urandom_range(1, 12);
            init = r2fp(real'($urandom_range(0, 50)) - 25.0);
            tot = fp2r(init);
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(rnd_bf()); qb.push_back(rnd_bf());
                tot = tot + fp2r({qa[i], 16'h0}) * fp2r({qb[i], 16'h0});
            end
            do_job(n, init, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, res);
            chk("rand_res", res, r2fp(tot));
        end

        // reset in the middle of a job
        qa.delete(); qb.delete();
        for (int i = 0; i < 4; i++) begin qa.push_back(rnd_bf()); qb.push_back(rnd_bf()); end
        bus.start = 1'b1; bus.len = LEN_W'(4); bus.init_acc = 32'h40400000;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_a = qa[i]; bus.in_b = qb[i];
            cyc();
        end
        rst = 1'b1; bus.in_a = qa[2]; bus.in_b = qb[2];
        cyc();
        mid();
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_vld", 32'(bus.res_valid), 0);
        chk("mrst_acc", bus.fma_c, 0);
        chk("mrst_rdy", 32'(bus.in_ready), 0);
        cyc();
        rst = 1'b0; bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid(); chk("mrst_novld", 32'(bus.res_valid), 0);
            cyc();
        end
        qa = '{16'h4000}; qb = '{16'h4000};
        do_job(1, 32'h00000000, 0, 0, 1'b0, res);
        chk("after_rst_res", res, 32'h40800000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control stage that sits directly upstream of the combinational bf16×bf16+fp32 FMA unit and closes its accumulation loop. It accepts a dot-product job (length plus initial fp32 accumulator) and streams bf16 operand pairs into the FMA one per cycle. It feeds the FMA result back as the next addend and presents the final fp32 sum on a valid/ready result port. The FMA itself is external; this block only drives its operands and registers its output.

## Interface
- MAX_LEN, 256, largest supported job length (element pairs)
- LEN_W, $clog2(MAX_LEN+1), width of the length field and element counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- len  in  LEN_W  number of operand pairs in the job, 0..MAX_LEN
- init_acc  in  32  fp32 initial accumulator value (the first FMA addend)
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts an operand pair this cycle
- in_a  in  16  bf16 multiplicand
- in_b  in  16  bf16 multiplier
- fma_a  out  16  to FMA operand a
- fma_b  out  16  to FMA operand b
- fma_c  out  32  to FMA addend c (the current accumulator)
- fma_out  in  32  from FMA result, combinational a*b+c
- res_valid  out  1  final sum valid
- res_ready  in  1  consumer accepts result
- res_data  out  32  final fp32 sum
- busy  out  1  job in progress (RUN or DONE)

## Operation
- State machine states: IDLE, RUN, DONE. Registers: acc[31:0] and cnt[LEN_W-1:0].
- IDLE:
  - in_ready=0, res_valid=0, busy=0.
  - start=1 with len≠0: acc←init_acc, cnt←len, go to RUN.
  - start=1 with len=0: acc←init_acc, go directly to DONE (result = init_acc).
  - len>MAX_LEN is not a legal input; behaviour is undefined.
- RUN:
  - in_ready=1, busy=1.
  - fma_a=in_a, fma_b=in_b, fma_c=acc.
  - On a handshake (in_valid&in_ready): acc←fma_out, cnt←cnt−1.
  - A handshake with cnt=1 moves to DONE.
  - in_valid=0 stalls the job with acc and cnt held.
- DONE:
  - res_valid=1, res_data=acc, busy=1, in_ready=0.
  - res_ready=1 returns to IDLE; otherwise res_data is held stable.
- Outside RUN, fma_a=0 and fma_b=0. fma_c=acc in all states.
- start is ignored in RUN and DONE. It is also ignored in the DONE→IDLE transition cycle; a new job requires start in a cycle where the state is IDLE.
- No arithmetic is performed in this block. acc is a plain 32-bit register; sign, exponent and mantissa pass through bit-exact from fma_out.

## Timing
- Reset: state=IDLE, acc=0, cnt=0.
  - Output values under reset: in_ready=0, res_valid=0, res_data=0, busy=0, fma_a=0, fma_b=0, fma_c=0.
- rst asserted mid-job (RUN or DONE) forces IDLE on the next edge. The partial sum is discarded, and no res_valid pulse is generated.
- Throughput: one operand pair per cycle in RUN. The acc→FMA→acc path is a single-cycle combinational loop through the external FMA.
- Latency for a job of N≥1 pairs with no stalls:
  - start edge → RUN; the N handshakes occur on the following N cycles.
  - res_valid rises the cycle after the Nth handshake.
- len=0: res_valid rises the cycle after start.
- res_valid/res_data obey valid/ready rules: once asserted, they stay stable until the res_ready handshake.
- With res_valid and res_ready both high, the handshake completes that edge; res_valid=0 in the next cycle.

## Test plan
For these scenarios, the bench drives fma_out from an ideal fp32 model of a*b+c.
- Reset then idle: assert rst for 2 cycles -> all outputs 0, busy=0, in_ready=0; start ignored while rst=1.
- Basic job: len=2, init_acc=0x3F800000; pairs (0x3F80,0x4000), (0x3F80,0x4000) on consecutive cycles.
  - fma_c sequence 0x3F800000, 0x40400000.
  - res_data=0x40A00000, res_valid 1 cycle after the 2nd handshake.
- Stalls/backpressure: same job with in_valid low for 3 cycles between pairs, and res_ready low for 4 cycles.
  - acc/cnt hold during stalls; res_data stays 0x40A00000 while res_valid=1.
  - Completes on the res_ready edge.
- Zero length: len=0, init_acc=0xC0000000 -> no in_ready; res_valid=1 next cycle with res_data=0xC0000000.
- Ignored start / back-to-back: pulse start during RUN with a different init_acc -> no effect on acc.
  - After the result handshake, a start in IDLE begins a new job correctly.
- Reset mid-job: len=4; assert rst after 2 handshakes -> IDLE next cycle, acc=0, res_valid never asserted; a subsequent job of len=1 (0x4000,0x4000, init 0) yields 0x40800000.
